// File: rtl/dmem_arbiter.sv
// Round-robin, burst-limited arbiter sharing one single-port data memory
// between the core load/store port (requester 0) and a secondary master (requester 1).
module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        R0_REQ,
    input  logic        R0_WE,
    input  logic [31:0] R0_A,
    input  logic [31:0] R0_WD,
    input  logic        R1_REQ,
    input  logic        R1_WE,
    input  logic [31:0] R1_A,
    input  logic [31:0] R1_WD,
    output logic        R0_GNT,
    output logic        R1_GNT,
    output logic        R0_VALID,
    output logic        R1_VALID,
    output logic [31:0] R0_RD,
    output logic [31:0] R1_RD,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_WD,
    output logic        MEM_WE,
    input  logic [31:0] MEM_RD
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          r0_vld_q, r1_vld_q;
    logic [31:0]   r0_rd_q, r1_rd_q;

    logic own_req, oth_req, own_we;
    logic acc0, acc1;

    always_comb begin
        R0_GNT  = (state_q == OWN) && !owner_q;
        R1_GNT  = (state_q == OWN) && owner_q;
        own_req = owner_q ? R1_REQ : R0_REQ;
        oth_req = owner_q ? R0_REQ : R1_REQ;
        own_we  = owner_q ? R1_WE  : R0_WE;
        acc0    = R0_GNT && R0_REQ;
        acc1    = R1_GNT && R1_REQ;

        // The memory sees a quiet bus whenever nobody owns it, so an async
        // reset drops MEM_WE immediately and aborts an in-flight write.
        MEM_A  = '0;
        MEM_WD = '0;
        MEM_WE = 1'b0;
        if (state_q == OWN) begin
            MEM_A  = owner_q ? R1_A  : R0_A;
            MEM_WD = owner_q ? R1_WD : R0_WD;
            MEM_WE = own_req && own_we;
        end

        R0_VALID = r0_vld_q;
        R1_VALID = r1_vld_q;
        R0_RD    = r0_rd_q;
        R1_RD    = r1_rd_q;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (R0_REQ || R1_REQ) begin
                    state_d = OWN;
                    burst_d = CW'(1);
                    if (R0_REQ && R1_REQ) owner_d = ~last_q;
                    else                  owner_d = R1_REQ;
                end
            end
            OWN: begin
                last_d = owner_q;
                if (!own_req) begin
                    if (oth_req) begin
                        owner_d = ~owner_q;
                        burst_d = CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (burst_q >= BURST_MAX && oth_req) begin
                    // Burst exhausted: this access still completes, then hand over.
                    owner_d = ~owner_q;
                    burst_d = CW'(1);
                end else if (burst_q < BURST_MAX) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            burst_q  <= '0;
            r0_vld_q <= 1'b0;
            r1_vld_q <= 1'b0;
            r0_rd_q  <= '0;
            r1_rd_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            r0_vld_q <= acc0;
            r1_vld_q <= acc1;
            if (acc0 && !R0_WE) r0_rd_q <= MEM_RD;
            if (acc1 && !R1_WE) r1_rd_q <= MEM_RD;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model and a reference memory.
module tb_dmem_arbiter;
    localparam int MAXB = 4;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
    } txn_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        R0_REQ, R1_REQ, R0_WE, R1_WE;
    logic [31:0] R0_A, R1_A, R0_WD, R1_WD;
    logic        R0_GNT, R1_GNT, R0_VALID, R1_VALID;
    logic [31:0] R0_RD, R1_RD;
    logic [31:0] MEM_A, MEM_WD, MEM_RD;
    logic        MEM_WE;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_own = 0, m_owner = 0, m_last = 1, m_run = 0;
    bit          m_acc [2];
    bit          exp_vld [2];
    logic [31:0] exp_rd [2];
    bit          m_rq [2];
    bit          m_we [2];
    logic [31:0] m_a [2];
    logic [31:0] m_wd [2];
    logic [31:0] sbq0 [$];
    logic [31:0] sbq1 [$];
    int          order_log [$];

    // stimulus state
    txn_t txq0 [$];
    txn_t txq1 [$];
    bit   hold [2];
    bit   auto_en = 1'b0;
    bit   eager   = 1'b1;

    dmem_arbiter #(.MAX_BURST(MAXB)) dut (
        .CLK(CLK), .RST(RST),
        .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_A(R0_A), .R0_WD(R0_WD),
        .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_A(R1_A), .R1_WD(R1_WD),
        .R0_GNT(R0_GNT), .R1_GNT(R1_GNT),
        .R0_VALID(R0_VALID), .R1_VALID(R1_VALID),
        .R0_RD(R0_RD), .R1_RD(R1_RD),
        .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
    );

    always #5 CLK = ~CLK;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3F);
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // device memory: combinational read, write on rising edge
    assign MEM_RD = mem[widx(MEM_A)];
    always @(posedge CLK) if (MEM_WE) mem[widx(MEM_A)] <= MEM_WD;

    task automatic fail(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        bad++;
        $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) fail(nm, act, exp);
        else total++;
    endtask

    // reference model: round-robin with burst cap, evaluated per edge
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_own = 0; m_owner = 0; m_last = 1; m_run = 0;
            for (int n = 0; n < 2; n++) begin
                m_acc[n] = 0; exp_vld[n] = 0; exp_rd[n] = '0;
            end
            sbq0.delete();
            sbq1.delete();
        end else begin
            m_rq[0] = R0_REQ; m_we[0] = R0_WE; m_a[0] = R0_A; m_wd[0] = R0_WD;
            m_rq[1] = R1_REQ; m_we[1] = R1_WE; m_a[1] = R1_A; m_wd[1] = R1_WD;
            for (int n = 0; n < 2; n++) begin
                m_acc[n]   = (m_own == 1) && (m_owner == n) && m_rq[n];
                exp_vld[n] = m_acc[n];
                if (m_acc[n]) begin
                    if (m_we[n]) ref_mem[widx(m_a[n])] = m_wd[n];
                    else         exp_rd[n] = ref_mem[widx(m_a[n])];
                    if (n == 0) sbq0.push_back(exp_rd[0]);
                    else        sbq1.push_back(exp_rd[1]);
                end
            end
            if (m_own == 0) begin
                if (m_rq[0] || m_rq[1]) begin
                    m_own   = 1;
                    m_run   = 1;
                    m_owner = (m_rq[0] && m_rq[1]) ? 1 - m_last : (m_rq[0] ? 0 : 1);
                end
            end else begin
                m_last = m_owner;
                if (!m_rq[m_owner]) begin
                    if (m_rq[1 - m_owner]) begin
                        m_owner = 1 - m_owner;
                        m_run   = 1;
                    end else begin
                        m_own = 0;
                    end
                end else if (m_run >= MAXB && m_rq[1 - m_owner]) begin
                    m_owner = 1 - m_owner;
                    m_run   = 1;
                end else if (m_run < MAXB) begin
                    m_run = m_run + 1;
                end
            end
        end
    end

    // monitor: compares outputs against the model away from the active edge
    always @(negedge CLK) begin
        logic        ew;
        logic [31:0] ea;
        logic [31:0] e;
        ew = (m_own == 1) && ((m_owner == 0) ? (R0_REQ && R0_WE) : (R1_REQ && R1_WE));
        ea = (m_own == 1) ? ((m_owner == 0) ? R0_A : R1_A) : 32'h0;
        chk("gnt0", R0_GNT, (m_own == 1) && (m_owner == 0));
        chk("gnt1", R1_GNT, (m_own == 1) && (m_owner == 1));
        chk("mem_we", MEM_WE, ew);
        chk("mem_a", MEM_A, ea);
        chk("vld0", R0_VALID, exp_vld[0]);
        chk("vld1", R1_VALID, exp_vld[1]);
        if (R0_VALID === 1'b1) begin
            order_log.push_back(0);
            if (sbq0.size() == 0) fail("sb0_unexpected", R0_RD, 32'h0);
            else begin
                e = sbq0.pop_front();
                chk("rd0", R0_RD, e);
            end
        end
        if (R1_VALID === 1'b1) begin
            order_log.push_back(1);
            if (sbq1.size() == 0) fail("sb1_unexpected", R1_RD, 32'h0);
            else begin
                e = sbq1.pop_front();
                chk("rd1", R1_RD, e);
            end
        end
        chk("held_rd0", R0_RD, exp_rd[0]);
        chk("held_rd1", R1_RD, exp_rd[1]);
    end

    // requester drivers: hold a request until the model says it completed
    always @(negedge CLK) begin
        #1;
        if (RST) begin
            hold[0] = 0;
            hold[1] = 0;
        end else begin
            if (m_acc[0]) begin
                if (txq0.size() > 0) void'(txq0.pop_front());
                hold[0] = 0;
            end
            if (m_acc[1]) begin
                if (txq1.size() > 0) void'(txq1.pop_front());
                hold[1] = 0;
            end
        end
        if (auto_en) begin
            if (!RST && !hold[0] && txq0.size() > 0 && (eager || $urandom_range(0, 2) != 0)) hold[0] = 1;
            if (!RST && !hold[1] && txq1.size() > 0 && (eager || $urandom_range(0, 2) != 0)) hold[1] = 1;
            R0_REQ = hold[0];
            R1_REQ = hold[1];
            if (txq0.size() > 0) begin
                R0_WE = txq0[0].we; R0_A = txq0[0].a; R0_WD = txq0[0].wd;
            end
            if (txq1.size() > 0) begin
                R1_WE = txq1[0].we; R1_A = txq1[0].a; R1_WD = txq1[0].wd;
            end
        end
    end

    function automatic txn_t mk(input bit we, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.we = we; t.a = a; t.wd = wd;
        return t;
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (txq0.size() == 0 && txq1.size() == 0 && m_own == 0 && !exp_vld[0] && !exp_vld[1])
                return;
        end
        fail("drain_timeout", 32'(txq0.size() + txq1.size()), 32'h0);
    endtask

    task automatic pulse_rst();
        @(negedge CLK); #1 RST = 1'b1;
        @(negedge CLK); #1 RST = 1'b0;
    endtask

    task automatic check_order(input string nm, input int n, input logic [15:0] pat);
        chk({nm, "_count"}, 32'(order_log.size()), 32'(n));
        for (int i = 0; i < n && i < order_log.size(); i++)
            chk({nm, "_who"}, 32'(order_log[i]), 32'(pat[i]));
    endtask

    initial begin
        RST = 1'b1;
        R0_REQ = 0; R1_REQ = 0; R0_WE = 0; R1_WE = 0;
        R0_A = '0; R1_A = '0; R0_WD = '0; R1_WD = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_gnt0", R0_GNT, 1'b0);
        chk("rst_gnt1", R1_GNT, 1'b0);
        chk("rst_memwe", MEM_WE, 1'b0);
        chk("rst_rd0", R0_RD, 32'h0);
        chk("rst_rd1", R1_RD, 32'h0);
        chk("rst_vld0", R0_VALID, 1'b0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // reset asserted while requester 0 holds a granted write
        #1 R0_WE = 1; R0_A = 32'h20; R0_WD = 32'hDEAD_BEEF; R0_REQ = 1;
        @(negedge CLK);
        #1 chk("midw_we_on", MEM_WE, 1'b1);
        RST = 1'b1;
        #1 chk("midw_we_abort", MEM_WE, 1'b0);
        chk("midw_gnt", R0_GNT, 1'b0);
        @(negedge CLK);
        #1 R0_REQ = 0; R0_WE = 0; RST = 1'b0;
        @(negedge CLK);
        chk("midw_mem_keep", mem[8], init_val(8));
        auto_en = 1'b1;

        // single write then read-back by requester 0
        order_log.delete();
        txq0.push_back(mk(1, 32'h4, 32'hA5A5_A5A5));
        txq0.push_back(mk(0, 32'h4, 32'h0));
        wait_drain();
        check_order("single", 2, 16'h0000);
        chk("single_rd", R0_RD, 32'hA5A5_A5A5);

        // tie from reset: requester 0 first, then 1 with no idle gap
        pulse_rst();
        order_log.delete();
        txq0.push_back(mk(0, 32'h4, 32'h0));
        txq1.push_back(mk(0, 32'h4, 32'h0));
        wait_drain();
        check_order("tie1", 2, 16'h0002);

        // requester 0 alone, then a tie: requester 1 wins
        txq0.push_back(mk(0, 32'h0, 32'h0));
        wait_drain();
        order_log.delete();
        txq0.push_back(mk(0, 32'h10, 32'h0));
        txq1.push_back(mk(0, 32'h14, 32'h0));
        wait_drain();
        check_order("tie2", 2, 16'h0001);

        // burst limit: 4 + 4 + remaining 2 + 2
        pulse_rst();
        order_log.delete();
        for (int i = 0; i < 6; i++) begin
            txq0.push_back(mk(i[0], 32'(16 + 4 * i), 32'h1111_0000 + 32'(i)));
            txq1.push_back(mk(0, 32'(16 + 4 * i), 32'h0));
        end
        wait_drain();
        check_order("burst", 12, 16'h0CF0);

        // cross-requester data and unwritten location
        txq1.push_back(mk(1, 32'h8, 32'h5A5A_5A5A));
        wait_drain();
        txq0.push_back(mk(0, 32'h8, 32'h0));
        wait_drain();
        chk("cross_rd", R0_RD, 32'h5A5A_5A5A);
        txq0.push_back(mk(0, 32'hC, 32'h0));
        wait_drain();
        chk("unwritten_rd", R0_RD, init_val(3));

        // random traffic
        eager = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge CLK);
            if (txq0.size() < 3 && $urandom_range(0, 2) == 0)
                txq0.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom));
            if (txq1.size() < 3 && $urandom_range(0, 2) == 0)
                txq1.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom));
        end
        eager = 1'b1;
        wait_drain();
        chk("final_sb0_empty", 32'(sbq0.size()), 32'h0);
        chk("final_sb1_empty", 32'(sbq1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port `MIPS_Data_Memory` (combinational read, write on rising `CLK`) between the core's load/store port (requester 0) and a secondary master such as a DMA or debug loader (requester 1). It arbitrates round-robin with a bounded burst length and drives the memory's `A`/`WD`/`WE` from the current owner. It returns registered read data and a one-cycle completion pulse to the owner.

## Interface
- `MAX_BURST`, default 4: maximum consecutive accesses an owner may complete while the other requester waits; must be ≥ 1.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `R0_REQ`, `R1_REQ`  in  1  access request; held high with stable `A`/`WE`/`WD` until sampled with own `GNT` at a rising edge.
- `R0_WE`, `R1_WE`  in  1  1 = write, 0 = read.
- `R0_A`, `R1_A`  in  32  byte address, passed through unmodified.
- `R0_WD`, `R1_WD`  in  32  write data.
- `R0_GNT`, `R1_GNT`  out  1  requester currently owns the memory (Moore output, from state only).
- `R0_VALID`, `R1_VALID`  out  1  one-cycle pulse: an access by this requester completed at the previous edge.
- `R0_RD`, `R1_RD`  out  32  registered read data of this requester's last completed read.
- `MEM_A`  out  32  to memory `A`.
- `MEM_WD`  out  32  to memory `WD`.
- `MEM_WE`  out  1  to memory `WE`.
- `MEM_RD`  in  32  from memory `RD`.

## Operation
- State: `IDLE` or `OWN`. Registers: `owner` (0/1), `last` (last owner), `burst_cnt` (width `$clog2(MAX_BURST+1)`).
- `GNTn` = (state == `OWN`) && (owner == n). At most one `GNT` is high at any time.
- Memory mux:
  - `OWN`: `MEM_A`/`MEM_WD` = owner's `A`/`WD`; `MEM_WE` = owner `REQ` && owner `WE`.
  - `IDLE`: `MEM_A` = 0, `MEM_WD` = 0, `MEM_WE` = 0.
- Completed access: a rising edge with `GNTn` && `Rn_REQ`. At that edge:
  - A write commits in memory.
  - A read captures `MEM_RD` into `Rn_RD`.
  - `Rn_VALID` is high for the following cycle, for both reads and writes.
  - `Rn_RD` is unchanged by writes and holds until this requester's next read.
- Transitions, evaluated at each rising edge (`other` = non-owner):
  - `IDLE`, no `REQ`: stay.
  - `IDLE`, one `REQ`: `OWN` with that requester, `burst_cnt` = 1.
  - `IDLE`, both `REQ`: `OWN` with the requester ≠ `last`, `burst_cnt` = 1.
  - `OWN`, owner `REQ` low, other `REQ` high: switch owner, `burst_cnt` = 1. No access is performed this cycle.
  - `OWN`, owner `REQ` low, other `REQ` low: go to `IDLE`.
  - `OWN`, owner `REQ` high, and (`burst_cnt` < `MAX_BURST` or other `REQ` low): stay; `burst_cnt` increments, saturating at `MAX_BURST`.
  - `OWN`, owner `REQ` high, `burst_cnt` == `MAX_BURST`, other `REQ` high: the access completes, then ownership switches to other with `burst_cnt` = 1.
  - `last` updates to the owner on every edge in `OWN`.
- A preempted requester keeps `REQ` high and is regranted by round-robin.

## Timing
- Reset values (asynchronous, immediate):
  - State `IDLE`, `GNT` = 0/0, `VALID` = 0/0.
  - `R0_RD` = `R1_RD` = 0, `burst_cnt` = 0.
  - `last` = 1, so requester 0 wins the first tie.
  - `MEM_WE` = 0.
- Reset mid-write: `MEM_WE` drops asynchronously and the write is aborted.
- From `IDLE`, with `REQ` first seen at edge k:
  - `GNT` is high after edge k.
  - The access completes at edge k+1.
  - `VALID` and `RD` are valid between edges k+1 and k+2.
- Steady state: one completed access per cycle for the owner.
- Owner handover (`OWN`→`OWN`) costs no idle cycle; `IDLE`→`OWN` costs one.
- `MEM_RD` is combinational from `MEM_A`. Requesters must not use `MEM_RD` directly, only `Rn_RD` qualified by `Rn_VALID`.
- A requester dropping `REQ` while granted performs no access and generates no `VALID`.

## Test plan
- Reset then idle: `GNT`=0, `MEM_WE`=0, `RD`=0.
- `RST` pulsed while `R0` holds a write: `MEM_WE` falls immediately, the location is unchanged, and state is `IDLE`.
- Single write/read:
  - `R0` writes `A`=4, `WD`=A5A5A5A5: `GNT0` after 1 edge, `VALID0` one cycle.
  - `R0` then reads `A`=4: `R0_RD`=A5A5A5A5 with `VALID0`.
- Tie from `IDLE`: both request from reset, so `R0` is granted first. After `R0` releases, `R1` is granted with no idle cycle. A second tie from `IDLE` grants `R1` if `last`=0.
- Burst limit:
  - `R0` holds `REQ` continuously and `R1` requests at the same time.
  - Exactly `MAX_BURST` (4) `R0` completions occur, then `GNT1` rises.
  - `R1` gets its burst, then `R0` resumes.
- Cross-requester data:
  - `R1` writes `A`=8, `WD`=5A5A5A5A; `R0` reads 8 and gets 5A5A5A5A.
  - `R1_RD` is unchanged by `R1`'s write and `R0_RD` is unchanged by `R1`'s accesses.
  - An unwritten `A`=12 reads the memory's initial content.
